// File: rtl/task_sequencer.sv
// Runs enabled submodules one after another (en -> start -> wait for done) and
// hands the single memory port to whichever task is currently being serviced.
module task_sequencer #(
  parameter int NUM_TASKS  = 4,
  parameter int WORD_WIDTH = 16,
  parameter int ADDR_WIDTH = 11,
  parameter int TIMEOUT    = 1023
) (
  input  logic                            clock,
  input  logic                            nrst,
  input  logic                            go,
  input  logic [NUM_TASKS-1:0]            task_mask,
  output logic [NUM_TASKS-1:0]            task_en,
  output logic [NUM_TASKS-1:0]            task_start,
  input  logic [NUM_TASKS-1:0]            task_done,
  input  logic [NUM_TASKS*ADDR_WIDTH-1:0] task_address,
  input  logic [NUM_TASKS-1:0]            task_wr_en,
  input  logic [NUM_TASKS*WORD_WIDTH-1:0] task_data_out,
  output logic [ADDR_WIDTH-1:0]           mem_address,
  output logic                            mem_wr_en,
  output logic [WORD_WIDTH-1:0]           mem_data_out,
  output logic                            busy,
  output logic                            done,
  output logic                            timeout_err,
  output logic [2:0]                      err_task
);

  // idx must reach NUM_TASKS (up to 8) to mark the end of the scan
  localparam int IDX_W = 4;
  localparam int TMR_W = 10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SCAN   = 3'd1,
    ENABLE = 3'd2,
    START  = 3'd3,
    WAIT   = 3'd4,
    FINISH = 3'd5
  } state_t;

  state_t               state_reg, state_next;
  logic [IDX_W-1:0]     idx_reg, idx_next;
  logic [TMR_W-1:0]     timer_reg, timer_next;
  logic [NUM_TASKS-1:0] mask_reg, mask_next;
  logic                 busy_reg, busy_next;
  logic                 done_reg, done_next;
  logic                 timeout_err_reg, timeout_err_next;
  logic [2:0]           err_task_reg, err_task_next;

  logic [NUM_TASKS-1:0] idx_onehot;
  logic                 cur_mask;
  logic                 cur_done;
  logic                 granted;
  logic [TMR_W-1:0]     timer_inc;

  // idx_onehot is all-zero once idx has walked past the last task
  generate
    for (genvar gi = 0; gi < NUM_TASKS; gi++) begin : g_sel
      assign idx_onehot[gi] = (idx_reg == IDX_W'(gi));
    end
  endgenerate

  assign cur_mask  = |(mask_reg & idx_onehot);
  assign cur_done  = |(task_done & idx_onehot);
  assign granted   = (state_reg == ENABLE) || (state_reg == START) || (state_reg == WAIT);
  assign timer_inc = timer_reg + TMR_W'(1);

  always_ff @(posedge clock) begin
    if (!nrst) begin
      state_reg       <= IDLE;
      idx_reg         <= '0;
      timer_reg       <= '0;
      mask_reg        <= '0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      timeout_err_reg <= 1'b0;
      err_task_reg    <= '0;
    end else begin
      state_reg       <= state_next;
      idx_reg         <= idx_next;
      timer_reg       <= timer_next;
      mask_reg        <= mask_next;
      busy_reg        <= busy_next;
      done_reg        <= done_next;
      timeout_err_reg <= timeout_err_next;
      err_task_reg    <= err_task_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    idx_next         = idx_reg;
    timer_next       = timer_reg;
    mask_next        = mask_reg;
    busy_next        = busy_reg;
    done_next        = done_reg;
    timeout_err_next = timeout_err_reg;
    err_task_next    = err_task_reg;
    case (state_reg)
      IDLE: begin
        if (go) begin
          mask_next        = task_mask;
          idx_next         = '0;
          done_next        = 1'b0;
          timeout_err_next = 1'b0;
          err_task_next    = '0;
          busy_next        = 1'b1;
          state_next       = SCAN;
        end
      end
      SCAN: begin
        if (idx_reg == IDX_W'(NUM_TASKS)) begin
          state_next = FINISH;
        end else if (!cur_mask) begin
          idx_next = idx_reg + IDX_W'(1);
        end else begin
          state_next = ENABLE;
        end
      end
      ENABLE: state_next = START;
      START: begin
        timer_next = '0;
        state_next = WAIT;
      end
      WAIT: begin
        // a done arriving on the final allowed cycle still counts as success
        if (cur_done) begin
          idx_next   = idx_reg + IDX_W'(1);
          state_next = SCAN;
        end else begin
          timer_next = timer_inc;
          if (timer_inc == TMR_W'(TIMEOUT)) begin
            timeout_err_next = 1'b1;
            err_task_next    = idx_reg[2:0];
            state_next       = FINISH;
          end
        end
      end
      FINISH: begin
        busy_next  = 1'b0;
        done_next  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    task_en      = '0;
    task_start   = '0;
    mem_address  = '0;
    mem_wr_en    = 1'b0;
    mem_data_out = '0;
    if (state_reg == ENABLE) task_en = idx_onehot;
    if (state_reg == START) task_start = idx_onehot;
    if (granted) begin
      for (int i = 0; i < NUM_TASKS; i++) begin
        if (idx_onehot[i]) begin
          mem_address  = task_address[i*ADDR_WIDTH +: ADDR_WIDTH];
          mem_wr_en    = task_wr_en[i];
          mem_data_out = task_data_out[i*WORD_WIDTH +: WORD_WIDTH];
        end
      end
    end
  end

  assign busy        = busy_reg;
  assign done        = done_reg;
  assign timeout_err = timeout_err_reg;
  assign err_task    = err_task_reg;

endmodule

// File: tb/tb_task_sequencer.sv
// Scoreboard bench for task_sequencer: stimulus plans each run's expected pulses,
// grant windows and completion from latencies; a negedge monitor pops and compares.
module tb_task_sequencer;
  localparam int NT  = 4;
  localparam int AW  = 11;
  localparam int WW  = 16;
  localparam int TMO = 1023;

  logic             clock = 1'b0;
  logic             nrst;
  logic             go;
  logic [NT-1:0]    task_mask;
  logic [NT-1:0]    task_en;
  logic [NT-1:0]    task_start;
  logic [NT-1:0]    task_done = '0;
  logic [NT*AW-1:0] task_address = '0;
  logic [NT-1:0]    task_wr_en = '0;
  logic [NT*WW-1:0] task_data_out = '0;
  logic [AW-1:0]    mem_address;
  logic             mem_wr_en;
  logic [WW-1:0]    mem_data_out;
  logic             busy;
  logic             done;
  logic             timeout_err;
  logic [2:0]       err_task;

  task_sequencer #(.NUM_TASKS(NT), .WORD_WIDTH(WW), .ADDR_WIDTH(AW), .TIMEOUT(TMO)) dut (
    .clock(clock), .nrst(nrst), .go(go), .task_mask(task_mask),
    .task_en(task_en), .task_start(task_start), .task_done(task_done),
    .task_address(task_address), .task_wr_en(task_wr_en), .task_data_out(task_data_out),
    .mem_address(mem_address), .mem_wr_en(mem_wr_en), .mem_data_out(mem_data_out),
    .busy(busy), .done(done), .timeout_err(timeout_err), .err_task(err_task)
  );

  always #5 clock = ~clock;

  typedef struct { int idx; int t; } ev_t;
  typedef struct { int idx; int t0; int t1; } grant_t;
  typedef struct { logic err; int idx; int t; } fin_t;

  ev_t    en_q[$];
  ev_t    st_q[$];
  grant_t grant_q[$];
  fin_t   fin_q[$];

  int cyc = 0;
  int n_vec = 0;
  int n_bad = 0;
  int lat[NT];
  bit never[NT];
  int done_at[NT] = '{default: -1};
  bit mon_on = 1'b0;
  bit wr_mode = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, cyc + 1);
    end
  endtask

  // Submodule models: done clears on en, rises lat cycles after start is seen.
  always @(posedge clock) begin
    cyc <= cyc + 1;
    for (int i = 0; i < NT; i++) begin
      if (task_en[i] === 1'b1) begin
        task_done[i] <= 1'b0;
        done_at[i]   <= -1;
      end else if (task_start[i] === 1'b1) begin
        if (never[i]) done_at[i] <= -1;
        else if (lat[i] == 1) task_done[i] <= 1'b1;
        else done_at[i] <= cyc + lat[i];
      end else if (done_at[i] == cyc + 1) begin
        task_done[i] <= 1'b1;
      end
    end
  end

  // Task buses: random traffic every cycle; wr_mode pins task 2's write and task 1's wr_en.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      for (int i = 0; i < NT; i++) begin
        task_address[i*AW +: AW]  = AW'($urandom);
        task_data_out[i*WW +: WW] = WW'($urandom);
        task_wr_en[i]             = 1'($urandom_range(0, 1));
      end
      if (wr_mode) begin
        task_address[2*AW +: AW]  = 11'h002;
        task_data_out[2*WW +: WW] = 16'h0001;
        task_wr_en[2]             = 1'b1;
        task_wr_en[1]             = 1'b1;
      end
    end
  end

  // Reference: edge numbers of every pulse, grant window and completion for go at edge g.
  task automatic plan_run(input int g, input logic [NT-1:0] m);
    int  c, e, s;
    bit  to;
    c  = g + 1;
    to = 1'b0;
    for (int i = 0; i < NT && !to; i++) begin
      if (!m[i]) begin
        c++;
      end else begin
        e = c + 1;
        s = c + 2;
        en_q.push_back(ev_t'{i, e});
        st_q.push_back(ev_t'{i, s});
        if (never[i] || lat[i] > TMO) begin
          grant_q.push_back(grant_t'{i, e, s + TMO});
          fin_q.push_back(fin_t'{1'b1, i, s + TMO + 2});
          to = 1'b1;
        end else begin
          grant_q.push_back(grant_t'{i, e, s + lat[i]});
          c = s + lat[i] + 1;
        end
      end
    end
    if (!to) fin_q.push_back(fin_t'{1'b0, 0, c + 2});
  endtask

  task automatic flush();
    en_q.delete();
    st_q.delete();
    grant_q.delete();
    fin_q.delete();
  endtask

  task automatic run(input logic [NT-1:0] m);
    @(posedge clock);
    #1;
    go = 1'b1;
    task_mask = m;
    plan_run(cyc + 1, m);
    @(posedge clock);
    #1;
    go = 1'b0;
    task_mask = NT'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (fin_q.size() != 0 && n < 3000) begin
      @(posedge clock);
      n++;
    end
    if (fin_q.size() != 0) begin
      chk("run_bound", fin_q.size(), 0);
      flush();
    end
    repeat (2) @(posedge clock);
  endtask

  task automatic set_all(input int l);
    for (int i = 0; i < NT; i++) begin
      lat[i]   = l;
      never[i] = 1'b0;
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_timeout_err"}, timeout_err, 0);
    chk({tag, "_err_task"}, err_task, 0);
    chk({tag, "_task_en"}, task_en, 0);
    chk({tag, "_task_start"}, task_start, 0);
    chk({tag, "_mem_wr_en"}, mem_wr_en, 0);
    chk({tag, "_mem_address"}, mem_address, 0);
    chk({tag, "_mem_data"}, mem_data_out, 0);
  endtask

  // Monitor: at each negedge, values about to be sampled at edge cyc+1.
  initial begin
    int          t;
    ev_t         e;
    fin_t        f;
    grant_t      g;
    logic        done_prev;
    logic [31:0] exp_a, exp_d, exp_w;
    done_prev = 1'b0;
    forever begin
      @(negedge clock);
      if (mon_on) begin
        t = cyc + 1;
        if (task_en != '0 || (en_q.size() != 0 && en_q[0].t <= t)) begin
          if (en_q.size() == 0) chk("en_unexpected", task_en, 0);
          else begin
            e = en_q.pop_front();
            chk("en_onehot", task_en, 32'(1) << e.idx);
            chk("en_edge", t, e.t);
            chk("busy_in_run", busy, 1);
          end
        end
        if (task_start != '0 || (st_q.size() != 0 && st_q[0].t <= t)) begin
          if (st_q.size() == 0) chk("start_unexpected", task_start, 0);
          else begin
            e = st_q.pop_front();
            chk("start_onehot", task_start, 32'(1) << e.idx);
            chk("start_edge", t, e.t);
          end
        end
        if ((done && !done_prev) || (fin_q.size() != 0 && fin_q[0].t <= t)) begin
          if (fin_q.size() == 0) chk("done_unexpected", done, 0);
          else begin
            f = fin_q.pop_front();
            chk("done_level", done, 1);
            chk("done_edge", t, f.t);
            chk("busy_end", busy, 0);
            chk("timeout_err", timeout_err, 32'(f.err));
            chk("err_task", err_task, f.idx);
          end
        end
        done_prev = done;
        while (grant_q.size() != 0 && grant_q[0].t1 < t) grant_q.delete(0);
        exp_a = 0;
        exp_d = 0;
        exp_w = 0;
        if (grant_q.size() != 0 && grant_q[0].t0 <= t) begin
          g = grant_q[0];
          exp_a = 32'(task_address[g.idx*AW +: AW]);
          exp_d = 32'(task_data_out[g.idx*WW +: WW]);
          exp_w = 32'(task_wr_en[g.idx]);
        end
        chk("mem_wr_en", mem_wr_en, exp_w);
        chk("mem_address", mem_address, exp_a);
        chk("mem_data", mem_data_out, exp_d);
      end
    end
  end

  initial begin
    nrst = 1'b0;
    go = 1'b1;
    task_mask = '1;
    set_all(5);
    repeat (2) @(posedge clock);
    #1;
    chk_quiet("reset");
    nrst = 1'b0;
    go = 1'b0;
    nrst = 1'b1;
    mon_on = 1'b1;

    set_all(5);
    run(4'b1111);
    wait_idle();

    wr_mode = 1'b1;
    run(4'b0101);
    wait_idle();
    wr_mode = 1'b0;

    set_all(4);
    never[1] = 1'b1;
    run(4'b0011);
    wait_idle();
    never[1] = 1'b0;

    run(4'b0000);
    wait_idle();

    lat[0] = TMO;
    run(4'b0001);
    wait_idle();
    lat[0] = TMO + 1;
    run(4'b0001);
    wait_idle();

    // second go while busy, then reset while task 0 is waiting
    set_all(30);
    run(4'b1111);
    repeat (2) @(posedge clock);
    #1;
    go = 1'b1;
    task_mask = 4'b0010;
    @(posedge clock);
    #1;
    go = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    nrst = 1'b0;
    @(posedge clock);
    #1;
    flush();
    chk_quiet("mid_reset");
    nrst = 1'b1;
    repeat (2) @(posedge clock);
    set_all(3);
    run(4'b1111);
    wait_idle();

    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < NT; i++) begin
        lat[i]   = $urandom_range(1, 12);
        never[i] = 1'b0;
      end
      run(NT'($urandom));
      wait_idle();
    end

    repeat (4) @(posedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
